// File: rtl/message_capture_pkg.sv
// Shared character codes and FSM encoding for the keyboard message path
// (capture, printer and ROM blocks all import this).
package message_capture_pkg;

    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_PAD = 8'h20;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic is_backspace(input logic [7:0] b);
        return (b == CHAR_BS) || (b == CHAR_DEL);
    endfunction

endpackage

// File: rtl/message_capture.sv
// Collects printable keyboard bytes into a padded line buffer; outputs update 1 cycle after a strobe.
// No rx backpressure: bytes arriving while a message is held are dropped until msg_ack releases it.
module message_capture
    import message_capture_pkg::*;
#(
    parameter int         MSG_LEN  = 8,
    parameter logic [7:0] PAD_CHAR = CHAR_PAD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 new_rx_data,
    input  logic                 msg_ack,
    output logic [8*MSG_LEN-1:0] bits_out,
    output logic [3:0]           msg_len,
    output logic                 msg_valid,
    output logic                 overflow
);

    localparam logic [3:0] LEN_MAX = 4'(MSG_LEN);

    state_t               r_state;
    state_t               w_next;
    logic [8*MSG_LEN-1:0] r_bits;
    logic [3:0]           r_len;
    logic                 r_ovf;

    logic w_rx_collect;
    logic w_push;
    logic w_drop;
    logic w_bksp;
    logic w_enter;
    logic w_clear;

    assign w_rx_collect = new_rx_data && (r_state == ST_COLLECT);
    assign w_push  = w_rx_collect && is_printable(rx_data) && (r_len != LEN_MAX);
    assign w_drop  = w_rx_collect && is_printable(rx_data) && (r_len == LEN_MAX);
    assign w_bksp  = w_rx_collect && is_backspace(rx_data) && (r_len != 4'd0);
    assign w_enter = w_rx_collect && (rx_data == CHAR_CR);
    assign w_clear = (r_state == ST_HOLD) && msg_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_enter) w_next = ST_HOLD;
            ST_HOLD:    if (msg_ack) w_next = ST_COLLECT;
            default:    w_next = ST_COLLECT;
        endcase
    end

    always_comb begin
        msg_valid = (r_state == ST_HOLD);
        bits_out  = r_bits;
        msg_len   = r_len;
        overflow  = r_ovf;
    end

    // Holding freezes the buffer simply because no collect-side enable can fire in ST_HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits <= {MSG_LEN{PAD_CHAR}};
            r_len  <= 4'd0;
            r_ovf  <= 1'b0;
        end else if (w_clear) begin
            r_bits <= {MSG_LEN{PAD_CHAR}};
            r_len  <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_len <= r_len + 4'd1;
            end else if (w_bksp) begin
                r_len <= r_len - 4'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            for (int j = 0; j < MSG_LEN; j++) begin
                if (w_push && (r_len == 4'(j))) begin
                    r_bits[8*j +: 8] <= rx_data;
                end else if (w_bksp && (r_len == 4'(j + 1))) begin
                    r_bits[8*j +: 8] <= PAD_CHAR;
                end
            end
        end
    end

endmodule

// File: tb/tb_message_capture.sv
// Directed bench for message_capture with hand-computed expected values.
module tb_message_capture;

    localparam logic [63:0] ALL_PAD = 64'h2020_2020_2020_2020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        new_rx_data = 1'b0;
    logic        msg_ack = 1'b0;
    logic [63:0] bits_out;
    logic [3:0]  msg_len;
    logic        msg_valid;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    message_capture #(.MSG_LEN(8), .PAD_CHAR(8'h20)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .msg_ack     (msg_ack),
        .bits_out    (bits_out),
        .msg_len     (msg_len),
        .msg_valid   (msg_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic ack(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        msg_ack     = 1'b1;
        rx_data     = b;
        new_rx_data = with_byte;
        @(negedge clk);
        msg_ack     = 1'b0;
        new_rx_data = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(msg_valid), 64'd0);
        check({tag, "_len"},   64'(msg_len),   64'd0);
        check({tag, "_ovf"},   64'(overflow),  64'd0);
        check({tag, "_bits"},  bits_out,       ALL_PAD);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // ack in COLLECT must be ignored
        send("A");
        ack(1'b0, 8'h00);
        check("ack_collect_len", 64'(msg_len), 64'd1);
        check("ack_collect_bits", bits_out, 64'h2020_2020_2020_2041);
        send(8'h08);
        check("bs_to_empty", bits_out, ALL_PAD);

        send_str("HI");
        send(8'h0D);
        check("hi_valid", 64'(msg_valid), 64'd1);
        check("hi_len", 64'(msg_len), 64'd2);
        check("hi_bits", bits_out, 64'h2020_2020_2020_4948);
        check("hi_ovf", 64'(overflow), 64'd0);
        ack(1'b0, 8'h00);
        check_cleared("hi_ack");

        send_str("ABCDEFGH");
        check("full_len", 64'(msg_len), 64'd8);
        check("full_ovf", 64'(overflow), 64'd0);
        send_str("IJ");
        send(8'h0D);
        check("ovf_valid", 64'(msg_valid), 64'd1);
        check("ovf_len", 64'(msg_len), 64'd8);
        check("ovf_bits", bits_out, 64'h4847_4645_4443_4241);
        check("ovf_flag", 64'(overflow), 64'd1);
        ack(1'b0, 8'h00);
        check_cleared("ovf_ack");

        // backspace past empty, DEL as backspace, LF ignored
        send_str("AB");
        send(8'h08);
        send(8'h7F);
        send(8'h08);
        check("bs_underflow_len", 64'(msg_len), 64'd0);
        send("C");
        send(8'h0A);
        send(8'h0D);
        check("bs_len", 64'(msg_len), 64'd1);
        check("bs_bits", bits_out, 64'h2020_2020_2020_2043);
        check("bs_valid", 64'(msg_valid), 64'd1);

        send("Z");
        check("hold_len", 64'(msg_len), 64'd1);
        check("hold_bits", bits_out, 64'h2020_2020_2020_2043);
        check("hold_valid", 64'(msg_valid), 64'd1);
        ack(1'b1, "Y");
        check_cleared("ack_byte");
        @(negedge clk);
        check("ack_byte_dropped", 64'(msg_len), 64'd0);

        send(8'h0D);
        check("empty_valid", 64'(msg_valid), 64'd1);
        check("empty_len", 64'(msg_len), 64'd0);
        ack(1'b0, 8'h00);

        send("K");
        send(8'h0D);
        check("pre_rst_valid", 64'(msg_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_cleared("async_rst");
        @(negedge clk);
        rst         = 1'b0;
        rx_data     = "Q";
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        check("first_strobe_len", 64'(msg_len), 64'd1);
        send(8'h0D);
        check("post_rst_valid", 64'(msg_valid), 64'd1);
        check("post_rst_len", 64'(msg_len), 64'd1);
        check("post_rst_bits", bits_out, 64'h2020_2020_2020_2051);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/message_capture.md
MESSAGE_CAPTURE -- requirements
Module: message_capture

Interface
REQ-001 SHALL have parameter MSG_LEN, default 8: maximum number of characters held per message.
REQ-002 SHALL have parameter PAD_CHAR, default 8'h20 (space): fill value for unused character slots.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: received keyboard byte.
REQ-006 SHALL have port new_rx_data, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port msg_ack, input, 1 bit: the printer has consumed the message.
REQ-008 SHALL have port bits_out, output, 8*MSG_LEN bits: packed message, character j at bits [8j+7:8j], j=0 first typed.
REQ-009 SHALL have port msg_len, output, 4 bits: count of valid characters, 0..MSG_LEN.
REQ-010 SHALL have port msg_valid, output, 1 bit: a complete message is held and stable.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag; one or more characters were dropped in the current message.

Function
REQ-012 SHALL implement a state machine with states COLLECT and HOLD.
REQ-013 COLLECT, new_rx_data with printable byte (8'h20..8'h7E) and msg_len<MSG_LEN: SHALL write the byte to slot msg_len and increment msg_len, both visible the next cycle.
REQ-014 COLLECT, printable byte with msg_len==MSG_LEN: SHALL drop the byte, leave bits_out/msg_len unchanged, and set overflow.
REQ-015 COLLECT, byte 8'h08 or 8'h7F (backspace): SHALL restore slot msg_len-1 to PAD_CHAR and decrement msg_len; when msg_len==0 it SHALL do nothing (no underflow).
REQ-016 COLLECT, byte 8'h0D (Enter): SHALL move to HOLD and assert msg_valid the next cycle; Enter with msg_len==0 SHALL be accepted (empty message).
REQ-017 COLLECT, any other byte (incl. 8'h0A): SHALL be ignored.
REQ-018 HOLD: msg_valid SHALL be 1; bits_out, msg_len and overflow SHALL be frozen; every new_rx_data SHALL be ignored.
REQ-019 HOLD with msg_ack=1: SHALL return to COLLECT the next cycle with msg_valid=0, msg_len=0, overflow=0, and every slot = PAD_CHAR.
REQ-020 msg_ack in COLLECT SHALL be ignored.
REQ-021 new_rx_data and msg_ack in the same HOLD cycle: the byte SHALL be dropped and the clear of REQ-019 applied.
REQ-022 All outputs SHALL be registered; latency from strobe to updated outputs is exactly 1 cycle.

Reset
REQ-023 rst=1 SHALL immediately force state=COLLECT, msg_len=0, msg_valid=0, overflow=0, every slot=PAD_CHAR, independent of clk.
REQ-024 Reset asserted in HOLD SHALL discard the held message with no msg_ack required.
REQ-025 The first strobe sampled on the first rising edge after rst deasserts SHALL be processed normally.

Structure
REQ-026 Character codes (BS, DEL, CR, LF, PAD) and state encodings SHALL be constants in a shared package, reused by the printer and ROM blocks.
REQ-027 The design SHALL be a single module; no sub-module is required.

Verification
REQ-028 Type "HI" then 8'h0D -> msg_valid=1, msg_len=2, bits_out[15:0]=16'h4948, bits_out[63:16] all 8'h20.
REQ-029 Type 10 chars "ABCDEFGHIJ" then CR -> msg_len=8, bits_out holds "ABCDEFGH", overflow=1.
REQ-030 Type "AB", BS, BS, BS, "C", CR -> msg_len=1, bits_out[7:0]=8'h43, slot 1 = 8'h20, no underflow.
REQ-031 In HOLD send "Z"; pulse msg_ack together with another byte -> "Z" and the byte ignored; next cycle msg_valid=0, msg_len=0, all slots 8'h20.
REQ-032 Assert rst asynchronously mid-HOLD between clock edges -> outputs reach reset values before the next edge; "Q",CR afterwards -> msg_len=1, bits_out[7:0]=8'h51.
